// File: rtl/mem_wb_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_pipe_pkg
// Purpose  : Shared definitions for the MEM->WB stage. This file holds the
//            default field widths, the idle constants, and the writeback
//            payload layout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_wb_pipe_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int DATA_W_DEF     = 32;

    localparam logic [REG_ADDR_W_DEF-1:0] NOP_REG_ADDR = '0;
    localparam logic [DATA_W_DEF-1:0]     ZERO_WORD    = '0;

    // Payload layout at the default widths. The top module declares the same
    // field order with its own parameter widths.
    typedef struct packed {
        logic [REG_ADDR_W_DEF-1:0] wd;
        logic                      wreg;
        logic [DATA_W_DEF-1:0]     wdata;
        logic                      whilo;
        logic [DATA_W_DEF-1:0]     hi;
        logic [DATA_W_DEF-1:0]     lo;
    } wb_payload_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_pipe_if
// Purpose  : Valid/ready writeback bus. It carries one register-file write
//            and one HI/LO write.
// Ports    : valid, ready, wd, wreg, wdata, whilo, hi, lo
//            master drives valid and the payload, and samples ready.
//            slave drives ready, and samples valid and the payload.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_wb_pipe_if
    import mem_wb_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) ();

    logic                  valid;
    logic                  ready;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic                  whilo;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;

    modport master (
        output valid, wd, wreg, wdata, whilo, hi, lo,
        input  ready
    );

    modport slave (
        input  valid, wd, wreg, wdata, whilo, hi, lo,
        output ready
    );

endinterface
`default_nettype wire

// File: rtl/mem_wb_pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : skid_buf
// Purpose  : A generic two-entry valid/ready skid buffer with a synchronous
//            flush. The main entry drives the output. The skid entry catches
//            the one extra beat that arrives while the downstream stalls.
// Ports    : clk, rst      clock and synchronous active-high reset
//            flush_i       drops both entries at the next edge
//            valid_i/ready_o/data_i   upstream side (ready_o is registered)
//            valid_o/ready_i/data_o   downstream side
// Revision : 1.0 - initial release
// ============================================================================
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q,  main_data_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         accept;
    logic         retire;
    logic         main_free;

    // ready_o depends only on skid occupancy. This keeps it a pure flop output
    // with no path from ready_i.
    assign ready_o   = !skid_valid_q;
    assign valid_o   = main_valid_q;
    assign data_o    = main_data_q;

    assign accept    = valid_i && ready_o;
    assign retire    = main_valid_q && ready_i;
    assign main_free = !main_valid_q || retire;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;

        if (main_free) begin
            // A full skid implies ready_o=0, so no accept can race this refill.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = data_i;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = data_i;
        end

        // Flush overrides the refill and the accept. A retire happening in
        // this cycle has already completed downstream.
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Payload registers need no reset. Their valid bits qualify them.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_pipe
// Purpose  : The MEM->WB pipeline stage with a valid/ready handshake. It
//            carries the register-file write and the HI/LO write through a
//            two-entry skid buffer. It zero-gates the payload whenever
//            out_valid is low, and counts retired writebacks in a saturating
//            counter.
// Ports    : clk, rst     clock and synchronous active-high reset
//            flush        discards every buffered entry
//            in_if        slave side: payload from MEM
//            out_if       master side: payload to WB
//            retire_cnt   count of completed output handshakes (saturates)
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    mem_wb_pipe_if.slave      in_if,
    mem_wb_pipe_if.master     out_if,
    output logic [CNT_W-1:0]  retire_cnt
);

    // The field order matches wb_payload_t. The widths come from this module's
    // parameters.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [DATA_W-1:0]     wdata;
        logic                  whilo;
        logic [DATA_W-1:0]     hi;
        logic [DATA_W-1:0]     lo;
    } payload_t;

    localparam int              PAYLOAD_W = $bits(payload_t);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    payload_t              in_pl;
    payload_t              main_pl;
    logic [PAYLOAD_W-1:0]  main_bits;
    logic                  main_valid;
    logic [CNT_W-1:0]      retire_cnt_q, retire_cnt_d;

    assign in_pl = '{wd:    in_if.wd,
                     wreg:  in_if.wreg,
                     wdata: in_if.wdata,
                     whilo: in_if.whilo,
                     hi:    in_if.hi,
                     lo:    in_if.lo};

    skid_buf #(
        .W (PAYLOAD_W)
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .valid_i (in_if.valid),
        .ready_o (in_if.ready),
        .data_i  (in_pl),
        .valid_o (main_valid),
        .ready_i (out_if.ready),
        .data_o  (main_bits)
    );

    assign main_pl = payload_t'(main_bits);

    // Zero-gate the payload so that WB never sees a stale write enable or data
    // from a retired or flushed entry.
    assign out_if.valid = main_valid;
    assign out_if.wd    = main_valid ? main_pl.wd    : '0;
    assign out_if.wreg  = main_valid ? main_pl.wreg  : 1'b0;
    assign out_if.wdata = main_valid ? main_pl.wdata : '0;
    assign out_if.whilo = main_valid ? main_pl.whilo : 1'b0;
    assign out_if.hi    = main_valid ? main_pl.hi    : '0;
    assign out_if.lo    = main_valid ? main_pl.lo    : '0;

    // The counter sees the retire even in a flush cycle. It is cleared only
    // by reset.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (main_valid && out_if.ready && (retire_cnt_q != CNT_MAX)) begin
            retire_cnt_d = retire_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_pipe
// Purpose  : A self-checking bench for mem_wb_pipe. The reference is a
//            bounded FIFO of capacity 2, kept in a queue, plus a saturating
//            retire count. A second instance with CNT_W=3 covers counter
//            saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe;
    import mem_wb_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        sat_flush;
    logic [31:0] retire_cnt;
    logic [2:0]  sat_cnt;

    always #5 clk = ~clk;

    mem_wb_pipe_if #(.REG_ADDR_W(REG_ADDR_W_DEF), .DATA_W(DATA_W_DEF)) in_if ();
    mem_wb_pipe_if #(.REG_ADDR_W(REG_ADDR_W_DEF), .DATA_W(DATA_W_DEF)) out_if ();
    mem_wb_pipe_if #(.REG_ADDR_W(REG_ADDR_W_DEF), .DATA_W(DATA_W_DEF)) sat_in_if ();
    mem_wb_pipe_if #(.REG_ADDR_W(REG_ADDR_W_DEF), .DATA_W(DATA_W_DEF)) sat_out_if ();

    mem_wb_pipe #(.REG_ADDR_W(REG_ADDR_W_DEF), .DATA_W(DATA_W_DEF), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_if      (in_if),
        .out_if     (out_if),
        .retire_cnt (retire_cnt)
    );

    mem_wb_pipe #(.REG_ADDR_W(REG_ADDR_W_DEF), .DATA_W(DATA_W_DEF), .CNT_W(3)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .flush      (sat_flush),
        .in_if      (sat_in_if),
        .out_if     (sat_out_if),
        .retire_cnt (sat_cnt)
    );

    // Reference state
    wb_payload_t q[$];
    wb_payload_t cur_pl;
    logic [31:0] m_cnt;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          acc;
    bit          ret;
    int          acc_total;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic wb_payload_t rand_pl();
        wb_payload_t p;
        p.wd    = 5'($urandom);
        p.wreg  = 1'($urandom);
        p.wdata = $urandom;
        p.whilo = 1'($urandom);
        p.hi    = $urandom;
        p.lo    = $urandom;
        return p;
    endfunction

    task automatic drive(input wb_payload_t p);
        cur_pl      = p;
        in_if.wd    = p.wd;
        in_if.wreg  = p.wreg;
        in_if.wdata = p.wdata;
        in_if.whilo = p.whilo;
        in_if.hi    = p.hi;
        in_if.lo    = p.lo;
    endtask

    task automatic sat_drive(input wb_payload_t p);
        sat_in_if.wd    = p.wd;
        sat_in_if.wreg  = p.wreg;
        sat_in_if.wdata = p.wdata;
        sat_in_if.whilo = p.whilo;
        sat_in_if.hi    = p.hi;
        sat_in_if.lo    = p.lo;
    endtask

    // Each cycle: compare outputs at the negedge against the FIFO model, then
    // advance the model on the posedge. Inputs change 1ns after the posedge.
    task automatic cycle();
        wb_payload_t h;
        @(negedge clk);
        if (q.size() > 0) h = q[0];
        else              h = '0;
        check_val("in_ready",   in_if.ready,   (q.size() < 2) ? 64'd1 : 64'd0);
        check_val("out_valid",  out_if.valid,  (q.size() > 0) ? 64'd1 : 64'd0);
        check_val("out_wd",     out_if.wd,     h.wd);
        check_val("out_wreg",   out_if.wreg,   h.wreg);
        check_val("out_wdata",  out_if.wdata,  h.wdata);
        check_val("out_whilo",  out_if.whilo,  h.whilo);
        check_val("out_hi",     out_if.hi,     h.hi);
        check_val("out_lo",     out_if.lo,     h.lo);
        check_val("retire_cnt", retire_cnt,    m_cnt);
        acc = in_if.valid && (q.size() < 2);
        ret = (q.size() > 0) && out_if.ready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (ret) begin
                void'(q.pop_front());
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            end
            if (flush) begin
                q.delete();
            end else if (acc) begin
                q.push_back(cur_pl);
                acc_total++;
            end
        end
        #1;
    endtask

    initial begin
        wb_payload_t p;
        rst = 1'b1; flush = 1'b0; sat_flush = 1'b0;
        in_if.valid = 1'b0; out_if.ready = 1'b0;
        sat_in_if.valid = 1'b0; sat_out_if.ready = 1'b0;
        drive('0); sat_drive('0);
        @(posedge clk); #1;
        q.delete(); m_cnt = 0; acc_total = 0;
        cycle();
        rst = 1'b0;

        // Streaming: 8 back-to-back payloads with no backpressure
        out_if.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            p = rand_pl(); p.wd = 5'(i); p.wdata = 32'h100 + 32'(i); p.wreg = 1'b1;
            drive(p); in_if.valid = 1'b1;
            cycle();
        end
        in_if.valid = 1'b0;
        cycle(); cycle();
        check_val("stream_retire_cnt", retire_cnt, 64'd8);

        // Backpressure: stall after the first payload, keep offering
        acc_total = 0;
        p = rand_pl(); p.wd = 5'h11; drive(p); in_if.valid = 1'b1;
        cycle();
        out_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (acc) begin
                p = rand_pl(); p.wd = 5'(5'h12 + 5'(i)); drive(p);
            end
            cycle();
        end
        check_val("bp_accepts", 64'(acc_total), 64'd2);
        check_val("bp_in_ready", in_if.ready, 64'd0);
        in_if.valid = 1'b0; out_if.ready = 1'b1;
        cycle(); cycle(); cycle();
        check_val("bp_retire_cnt", retire_cnt, 64'd10);

        // Flush with two buffered entries and out_ready low
        out_if.ready = 1'b0;
        p = rand_pl(); p.wd = 5'd3; drive(p); in_if.valid = 1'b1; cycle();
        p = rand_pl(); p.wd = 5'd4; drive(p); cycle();
        in_if.valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        check_val("flush_out_valid", out_if.valid, 64'd0);
        check_val("flush_out_wd",    out_if.wd,    64'd0);
        check_val("flush_in_ready",  in_if.ready,  64'd1);
        check_val("flush_cnt",       retire_cnt,   64'd10);
        cycle();

        // Flush coinciding with a retire of wd=5 and an accept of wd=6
        out_if.ready = 1'b1;
        p = rand_pl(); p.wd = 5'd5; drive(p); in_if.valid = 1'b1; cycle();
        p = rand_pl(); p.wd = 5'd6; drive(p); flush = 1'b1; cycle();
        flush = 1'b0; in_if.valid = 1'b0;
        check_val("flret_cnt", retire_cnt, 64'd11);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("flret_no_wd6", out_if.valid, 64'd0);
        end

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            flush        = ($urandom_range(0, 15) == 0);
            in_if.valid  = ($urandom_range(0, 3) != 0);
            out_if.ready = ($urandom_range(0, 2) != 0);
            drive(rand_pl());
            cycle();
        end
        rst = 1'b0; flush = 1'b0; in_if.valid = 1'b0; out_if.ready = 1'b1;
        cycle(); cycle();

        // Reset while both entries are full with HI/LO writes pending
        out_if.ready = 1'b0;
        p = rand_pl(); p.whilo = 1'b1; p.hi = 32'hDEAD; drive(p); in_if.valid = 1'b1;
        cycle(); cycle();
        in_if.valid = 1'b0;
        check_val("full_in_ready", in_if.ready, 64'd0);
        check_val("full_hi",       out_if.hi,   64'hDEAD);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("rst_out_valid", out_if.valid, 64'd0);
        check_val("rst_out_whilo", out_if.whilo, 64'd0);
        check_val("rst_out_hi",    out_if.hi,    64'd0);
        check_val("rst_cnt",       retire_cnt,   64'd0);
        check_val("rst_in_ready",  in_if.ready,  64'd1);
        cycle();

        // Saturation on the CNT_W=3 instance: 10 retires must read 7
        check_val("sat_cnt_start", sat_cnt, 64'd0);
        sat_out_if.ready = 1'b1; sat_in_if.valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            p = rand_pl(); p.wd = 5'(i); sat_drive(p);
            cycle();
        end
        sat_in_if.valid = 1'b0;
        cycle(); cycle();
        check_val("sat_cnt_final", sat_cnt, 64'd7);
        check_val("sat_out_valid", sat_out_if.valid, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
